multicycle_control: RTL and testbench

- Moore-style sequencer for a multicycle variant of the MIPS datapath: one shared instruction/data memory, an instruction register, and ALU reuse for PC+4 and branch-target computation.
- Decodes opcode/funct and drives per-cycle datapath enables and mux selects.
- Inserts wait states on a memory ready handshake and halts on memory timeout.
- Sits between the instruction register and the datapath, replacing the single-cycle control decoders.

---
 rtl/multicycle_control_if.sv | 44 ++++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundles the instruction-register fields, the memory
// handshake and every datapath control line of the multicycle MIPS sequencer.
//
// Memory handshake: mem_req acts as "valid" and mem_ready as "ready". While
// mem_req is high, iord and mem_write are held stable. The request completes
// on the first rising edge where mem_req and mem_ready are both high.
// mem_ready is ignored when no request is pending.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_dest;
  logic       reg_wsrc;
  logic       reg_write;
  logic       illegal;
  logic       halted;
  logic [3:0] state;

  // Sequencer side: reads the instruction fields and mem_ready, drives the controls.
  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_dest, reg_wsrc, reg_write,
           illegal, halted, state
  );

  // Datapath/memory side: the mirror image of the sequencer.
  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_dest, reg_wsrc, reg_write,
           illegal, halted, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for a multicycle MIPS datapath with one
// shared instruction/data memory. It waits on mem_ready in the memory states
// and halts when a memory request stays unanswered for TIMEOUT_CYCLES cycles
// (0 disables the timeout). Most control outputs are registered and decoded
// from the next state. ir_write and pc_write in FETCH follow mem_ready directly.
// Define MULTICYCLE_CTRL_ADDI_J_EN to add the addi and j instructions. Without
// it, both opcodes decode as illegal.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // The counter holds the number of wait cycles already spent. The timeout
  // fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
  localparam logic       TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
`endif
    S_ILLEGAL = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dest;
    logic       reg_wsrc;
    logic       reg_write;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl_q;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       in_mem_state;
  logic       fetch_done;
  logic       run;

  // Returns 1 when funct selects one of the supported R-type operations.
  function automatic logic funct_ok(input logic [5:0] fn);
    case (fn)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default:                                               funct_ok = 1'b0;
    endcase
  endfunction

  // Maps an R-type funct code to the ALU operation.
  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'b100010: alu_for_funct = ALU_SUB;
      6'b100100: alu_for_funct = ALU_AND;
      6'b100101: alu_for_funct = ALU_OR;
      6'b101010: alu_for_funct = ALU_SLT;
      default:   alu_for_funct = ALU_ADD;
    endcase
  endfunction

  // Returns the Moore control word for a state. Registering this for the next
  // state makes the outputs line up with the state register.
  function automatic ctrl_t outputs_for(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    case (s)
      S_FETCH:   begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.reg_wsrc = 1'b1; end
      S_MEMWR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC:    begin c.alu_src_a = 1'b1; c.alu_ctrl = alu_for_funct(fn); end
      S_ALUWB:   begin c.reg_write = 1'b1; c.reg_dest = 1'b1; end
      S_BRANCH:  begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = ALU_SUB;
        c.branch    = 1'b1;
        c.pc_src    = 2'b01;
      end
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:  c.reg_write = 1'b1;
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
`endif
      S_ILLEGAL: c.illegal = 1'b1;
      S_HALT:    c.halted = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

  assign in_mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign tmo_hit      = TMO_EN && (tmo_cnt == TMO_LAST);

  // Next-state decode. In a memory state, mem_ready takes priority over the timeout.
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:   nxt = bus.mem_ready ? S_DECODE : (tmo_hit ? S_HALT : S_FETCH);
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW)          nxt = S_MEMADR;
        else if (bus.opcode == OP_RTYPE && funct_ok(bus.funct))  nxt = S_EXEC;
        else if (bus.opcode == OP_BEQ)                           nxt = S_BRANCH;
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
        else if (bus.opcode == OP_ADDI)                          nxt = S_ADDIEX;
        else if (bus.opcode == OP_J)                             nxt = S_JUMP;
`endif
        else                                                     nxt = S_ILLEGAL;
      end
      S_MEMADR:  nxt = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = bus.mem_ready ? S_MEMWB : (tmo_hit ? S_HALT : S_MEMRD);
      S_MEMWB:   nxt = S_FETCH;
      S_MEMWR:   nxt = bus.mem_ready ? S_FETCH : (tmo_hit ? S_HALT : S_MEMWR);
      S_EXEC:    nxt = S_ALUWB;
      S_ALUWB:   nxt = S_FETCH;
      S_BRANCH:  nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
      S_ADDIEX:  nxt = S_ADDIWB;
      S_ADDIWB:  nxt = S_FETCH;
      S_JUMP:    nxt = S_FETCH;
`endif
      S_ILLEGAL: nxt = S_FETCH;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_FETCH;
    endcase
  end

  // State register, registered control word, and wait-cycle counter. The counter
  // clears on any state change, on mem_ready, and outside the memory states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ctrl_q  <= outputs_for(S_FETCH, bus.funct);
      tmo_cnt <= 8'd0;
    end else begin
      state  <= nxt;
      ctrl_q <= outputs_for(nxt, bus.funct);
      if (nxt != state || bus.mem_ready || !in_mem_state) begin
        tmo_cnt <= 8'd0;
      end else if (tmo_cnt != 8'hFF) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  // Strobes are forced low while reset is high, including the Mealy fetch writes.
  assign run        = ~reset;
  assign fetch_done = (state == S_FETCH) && bus.mem_ready;

  assign bus.mem_req   = ctrl_q.mem_req & run;
  assign bus.iord      = ctrl_q.iord;
  assign bus.mem_write = ctrl_q.mem_write & run;
  assign bus.ir_write  = fetch_done & run;
  assign bus.pc_write  = (ctrl_q.pc_write | fetch_done) & run;
  assign bus.branch    = ctrl_q.branch & run;
  assign bus.pc_src    = ctrl_q.pc_src;
  assign bus.alu_src_a = ctrl_q.alu_src_a;
  assign bus.alu_src_b = ctrl_q.alu_src_b;
  assign bus.alu_ctrl  = ctrl_q.alu_ctrl;
  assign bus.reg_dest  = ctrl_q.reg_dest;
  assign bus.reg_wsrc  = ctrl_q.reg_wsrc;
  assign bus.reg_write = ctrl_q.reg_write & run;
  assign bus.illegal   = ctrl_q.illegal & run;
  assign bus.halted    = ctrl_q.halted;
  assign bus.state     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control, built with a
// 4-cycle memory timeout. Each planned cycle pushes its stimulus and the expected
// control word into queues. The drain loop in each test drives one cycle per
// entry and compares the DUT outputs against the popped expectation.
module tb_multicycle_control;

  localparam int W = 23;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  logic         rst_q[$];
  logic [5:0]   op_q[$];
  logic [5:0]   fn_q[$];

  multicycle_control_if bus ();

  multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Expected control word for one cycle, taken from the state output table.
  function automatic logic [W-1:0] model(input logic [3:0] st, input logic [5:0] fn,
                                         input logic rdy, input logic rst);
    logic mr, io, mw, irw, pw, br, a, rd, ws, rw, il, h;
    logic [1:0] ps, b;
    logic [2:0] alu;
    {mr, io, mw, irw, pw, br, a, rd, ws, rw, il, h} = '0;
    ps  = 2'b00;
    b   = 2'b00;
    alu = 3'b010;
    case (st)
      4'd0:  begin mr = 1'b1; b = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  b = 2'b11;
      4'd2:  begin a = 1'b1; b = 2'b10; end
      4'd3:  begin mr = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; ws = 1'b1; end
      4'd5:  begin mr = 1'b1; io = 1'b1; mw = 1'b1; end
      4'd6: begin
        a = 1'b1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin a = 1'b1; alu = 3'b110; br = 1'b1; ps = 2'b01; end
      4'd9:  begin a = 1'b1; b = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pw = 1'b1; ps = 2'b10; end
      4'd12: il = 1'b1;
      4'd13: h = 1'b1;
      default: ;
    endcase
    if (rst) {mr, mw, irw, pw, br, rw, il} = '0;
    return {st, mr, io, mw, irw, pw, br, ps, a, b, alu, rd, ws, rw, il, h};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus.state, bus.mem_req, bus.iord, bus.mem_write, bus.ir_write, bus.pc_write,
            bus.branch, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
            bus.reg_dest, bus.reg_wsrc, bus.reg_write, bus.illegal, bus.halted};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic plan(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic rst);
    rdy_q.push_back(rdy);
    rst_q.push_back(rst);
    op_q.push_back(op);
    fn_q.push_back(fn);
    exp_q.push_back(model(st, fn, rdy, rst));
  endtask

  // Expands one instruction into its expected state sequence. fw is the number
  // of FETCH wait cycles. mw is the number of wait cycles in MEMRD or MEMWR.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    for (int i = 0; i < fw; i++) plan(4'd0, 1'b0, op, fn, 1'b0);
    plan(4'd0, 1'b1, op, fn, 1'b0);
    plan(4'd1, rnd_bit(), op, fn, 1'b0);
    if (op == OP_LW) begin
      plan(4'd2, rnd_bit(), op, fn, 1'b0);
      for (int i = 0; i < mw; i++) plan(4'd3, 1'b0, op, fn, 1'b0);
      plan(4'd3, 1'b1, op, fn, 1'b0);
      plan(4'd4, rnd_bit(), op, fn, 1'b0);
    end else if (op == OP_SW) begin
      plan(4'd2, rnd_bit(), op, fn, 1'b0);
      for (int i = 0; i < mw; i++) plan(4'd5, 1'b0, op, fn, 1'b0);
      plan(4'd5, 1'b1, op, fn, 1'b0);
    end else if (op == OP_R && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                fn == 6'b100101 || fn == 6'b101010)) begin
      plan(4'd6, rnd_bit(), op, fn, 1'b0);
      plan(4'd7, rnd_bit(), op, fn, 1'b0);
    end else if (op == OP_BEQ) begin
      plan(4'd8, rnd_bit(), op, fn, 1'b0);
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
    end else if (op == OP_ADDI) begin
      plan(4'd9, rnd_bit(), op, fn, 1'b0);
      plan(4'd10, rnd_bit(), op, fn, 1'b0);
    end else if (op == OP_J) begin
      plan(4'd11, rnd_bit(), op, fn, 1'b0);
`endif
    end else begin
      plan(4'd12, rnd_bit(), op, fn, 1'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_BEQ;
    bus.funct = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state: got %0d want 0", bus.state);
      end
      n_checks++;
      if ({bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.branch,
           bus.reg_write, bus.illegal, bus.halted} !== 8'b0) begin
        n_fail++;
        $display("FAIL reset_strobes: got %b want 00000000",
                 {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.branch,
                  bus.reg_write, bus.illegal, bus.halted});
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, bus.mem_req, bus.ir_write, bus.pc_write} !== {4'd0, 3'b111}) begin
      n_fail++;
      $display("FAIL reset_release: state/mem_req/ir_write/pc_write got %0d/%b%b%b want 0/111",
               bus.state, bus.mem_req, bus.ir_write, bus.pc_write);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_decode: got %0d want 1", bus.state);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.state !== 4'd8 || bus.branch !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_branch: state %0d branch %b want 8 1", bus.state, bus.branch);
    end
  endtask

  task automatic test_lw();
    logic [W-1:0] got, want;
    int wb_cnt;
    wb_cnt = 0;
    plan_instr(OP_LW, 6'($urandom_range(0, 63)), 0, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      reset = rst_q.pop_front();
      bus.opcode = op_q.pop_front();
      bus.funct = fn_q.pop_front();
      #1;
      got = observe();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lw_seq: state got %0d want %0d, word got %h want %h",
                 got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
      if (bus.reg_write && bus.reg_wsrc) wb_cnt++;
    end
    n_checks++;
    if (wb_cnt !== 1) begin
      n_fail++;
      $display("FAIL lw_memwb_count: got %0d want 1", wb_cnt);
    end
  endtask

  task automatic test_sw_wait();
    logic [W-1:0] got, want;
    int mw_cnt, rw_cnt;
    mw_cnt = 0;
    rw_cnt = 0;
    plan_instr(OP_SW, 6'b000000, 0, 3);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      reset = rst_q.pop_front();
      bus.opcode = op_q.pop_front();
      bus.funct = fn_q.pop_front();
      #1;
      got = observe();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL sw_seq: state got %0d want %0d, word got %h want %h",
                 got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
      if (bus.mem_write) mw_cnt++;
      if (bus.reg_write) rw_cnt++;
    end
    n_checks++;
    if (mw_cnt !== 4) begin
      n_fail++;
      $display("FAIL sw_mem_write_cycles: got %0d want 4", mw_cnt);
    end
    n_checks++;
    if (rw_cnt !== 0) begin
      n_fail++;
      $display("FAIL sw_reg_write: got %0d want 0", rw_cnt);
    end
  endtask

  task automatic test_rtype();
    logic [W-1:0] got, want;
    int il_cnt, rw_cnt;
    il_cnt = 0;
    rw_cnt = 0;
    plan_instr(OP_R, 6'b101010, 0, 0);
    plan_instr(OP_R, 6'b000111, 0, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      reset = rst_q.pop_front();
      bus.opcode = op_q.pop_front();
      bus.funct = fn_q.pop_front();
      #1;
      got = observe();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rtype_seq: state got %0d want %0d, word got %h want %h",
                 got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
      if (bus.illegal) il_cnt++;
      if (bus.reg_write) rw_cnt++;
    end
    n_checks++;
    if (il_cnt !== 1) begin
      n_fail++;
      $display("FAIL rtype_illegal_pulse: got %0d want 1", il_cnt);
    end
    n_checks++;
    if (rw_cnt !== 1) begin
      n_fail++;
      $display("FAIL rtype_reg_write: got %0d want 1", rw_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] got, want;
    // Four unanswered fetch cycles, then HALT, which stays put even with mem_ready high.
    for (int i = 0; i < 4; i++) plan(4'd0, 1'b0, OP_BEQ, 6'd0, 1'b0);
    plan(4'd13, 1'b1, OP_BEQ, 6'd0, 1'b0);
    plan(4'd13, 1'b0, OP_BEQ, 6'd0, 1'b0);
    plan(4'd13, 1'b1, OP_BEQ, 6'd0, 1'b1);
    // Ready on the fourth wait cycle beats the timeout.
    plan_instr(OP_BEQ, 6'd0, 3, 0);
    // Reset while lw waits in MEMRD.
    plan(4'd0, 1'b1, OP_LW, 6'd0, 1'b0);
    plan(4'd1, 1'b1, OP_LW, 6'd0, 1'b0);
    plan(4'd2, 1'b1, OP_LW, 6'd0, 1'b0);
    plan(4'd3, 1'b0, OP_LW, 6'd0, 1'b0);
    plan(4'd3, 1'b0, OP_LW, 6'd0, 1'b1);
    plan(4'd0, 1'b0, OP_LW, 6'd0, 1'b0);
    plan(4'd0, 1'b1, OP_LW, 6'd0, 1'b0);
    plan(4'd1, 1'b0, OP_LW, 6'd0, 1'b0);
    plan(4'd2, 1'b0, OP_LW, 6'd0, 1'b0);
    plan(4'd3, 1'b1, OP_LW, 6'd0, 1'b0);
    plan(4'd4, 1'b0, OP_LW, 6'd0, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      reset = rst_q.pop_front();
      bus.opcode = op_q.pop_front();
      bus.funct = fn_q.pop_front();
      #1;
      got = observe();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL timeout_seq: state got %0d want %0d, word got %h want %h",
                 got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [W-1:0] got, want;
    int jsrc_cnt;
    jsrc_cnt = 0;
    plan_instr(OP_BEQ, 6'd0, 0, 0);
    plan_instr(OP_J, 6'd0, 0, 0);
    plan_instr(OP_ADDI, 6'd0, 1, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      reset = rst_q.pop_front();
      bus.opcode = op_q.pop_front();
      bus.funct = fn_q.pop_front();
      #1;
      got = observe();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch_jump_seq: state got %0d want %0d, word got %h want %h",
                 got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
      if (bus.pc_src == 2'b10) jsrc_cnt++;
    end
    n_checks++;
`ifdef MULTICYCLE_CTRL_ADDI_J_EN
    if (jsrc_cnt !== 1) begin
      n_fail++;
      $display("FAIL jump_pc_src_cycles: got %0d want 1", jsrc_cnt);
    end
`else
    if (jsrc_cnt !== 0) begin
      n_fail++;
      $display("FAIL jump_pc_src_cycles: got %0d want 0", jsrc_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got, want;
    logic [5:0] op, fn;
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 9))
        0: begin op = OP_LW;  fn = 6'($urandom_range(0, 63)); end
        1: begin op = OP_SW;  fn = 6'($urandom_range(0, 63)); end
        2: begin op = OP_R;   fn = 6'b100000; end
        3: begin op = OP_R;   fn = 6'b100010; end
        4: begin op = OP_R;   fn = 6'b100100; end
        5: begin op = OP_R;   fn = 6'b100101; end
        6: begin op = OP_R;   fn = 6'b101010; end
        7: begin op = OP_BEQ; fn = 6'd0; end
        8: begin op = OP_R;   fn = 6'b000011; end
        default: begin op = OP_BAD; fn = 6'd0; end
      endcase
      plan_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      bus.mem_ready = rdy_q.pop_front();
      reset = rst_q.pop_front();
      bus.opcode = op_q.pop_front();
      bus.funct = fn_q.pop_front();
      #1;
      got = observe();
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back_seq: state got %0d want %0d, word got %h want %h",
                 got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_timeout();
    test_branch_jump();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
